// File: rtl/mesi_isc_coh_monitor.sv
// mesi_isc_coh_monitor
// Protocol monitor for the MESI intersection controller. It watches NUM_PORTS
// main-bus request/ack pairs and coherence-bus snoop/ack pairs, and reports
// instability, spurious ack, timeout and illegal-command violations.
// A violation is detected combinationally in one cycle and reported, registered,
// in the next cycle. When several violations occur together, the lowest port is
// reported first and then the lowest code. The sticky vector records every
// detected code.
// Optional feature: define MESI_MON_STATS_EN to get per-port saturating 16-bit
// counters of completed main-bus transactions on txn_cnt_o. When the macro is
// undefined, txn_cnt_o is tied to zero and no counter flops are built.
module mesi_isc_coh_monitor #(
    parameter int NUM_PORTS      = 4,
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int CBUS_CMD_WIDTH = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYC    = 64,
    parameter int TO_CNT_WIDTH   = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_PORTS*MBUS_CMD_WIDTH-1:0]  mbus_cmd_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]      mbus_addr_i,
    input  logic [NUM_PORTS-1:0]                 mbus_ack_i,
    input  logic [NUM_PORTS*CBUS_CMD_WIDTH-1:0]  cbus_cmd_i,
    input  logic [ADDR_WIDTH-1:0]                cbus_addr_i,
    input  logic [NUM_PORTS-1:0]                 cbus_ack_i,
    output logic                                 err_vld_o,
    output logic [2:0]                           err_code_o,
    output logic [2:0]                           err_port_o,
    output logic [4:0]                           err_sticky_o,
    output logic [NUM_PORTS*16-1:0]              txn_cnt_o
);

    localparam int NUM_CODES = 5;
    localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_NOP = MBUS_CMD_WIDTH'(32'd0);
    localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_MAX = MBUS_CMD_WIDTH'(32'd4);
    localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_NOP = CBUS_CMD_WIDTH'(32'd0);
    localparam logic [TO_CNT_WIDTH-1:0]   TO_LIMIT = TO_CNT_WIDTH'(TIMEOUT_CYC);
    localparam logic [TO_CNT_WIDTH-1:0]   TO_LAST  = TO_CNT_WIDTH'(TIMEOUT_CYC - 1);

    typedef enum logic {M_IDLE = 1'b0, M_WAIT = 1'b1} m_state_t;
    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} s_state_t;

    // Per-port views of the flattened buses
    logic [MBUS_CMD_WIDTH-1:0] m_cmd_s  [NUM_PORTS];
    logic [ADDR_WIDTH-1:0]     m_addr_s [NUM_PORTS];
    logic [CBUS_CMD_WIDTH-1:0] c_cmd_s  [NUM_PORTS];

    // Main-bus FSM state
    m_state_t                  m_state_r       [NUM_PORTS];
    m_state_t                  m_state_nxt_s   [NUM_PORTS];
    logic [MBUS_CMD_WIDTH-1:0] m_cap_cmd_r     [NUM_PORTS];
    logic [MBUS_CMD_WIDTH-1:0] m_cap_cmd_nxt_s [NUM_PORTS];
    logic [ADDR_WIDTH-1:0]     m_cap_addr_r    [NUM_PORTS];
    logic [ADDR_WIDTH-1:0]     m_cap_addr_nxt_s[NUM_PORTS];
    logic [TO_CNT_WIDTH-1:0]   to_cnt_r        [NUM_PORTS];
    logic [TO_CNT_WIDTH-1:0]   to_cnt_nxt_s    [NUM_PORTS];

    // Snoop FSM state
    s_state_t                  s_state_r       [NUM_PORTS];
    s_state_t                  s_state_nxt_s   [NUM_PORTS];
    logic [CBUS_CMD_WIDTH-1:0] s_cap_cmd_r     [NUM_PORTS];
    logic [CBUS_CMD_WIDTH-1:0] s_cap_cmd_nxt_s [NUM_PORTS];
    logic [ADDR_WIDTH-1:0]     s_cap_addr_r    [NUM_PORTS];
    logic [ADDR_WIDTH-1:0]     s_cap_addr_nxt_s[NUM_PORTS];

    // Violations and completions detected this cycle
    logic [NUM_CODES-1:0]      port_err_s      [NUM_PORTS];
    logic [NUM_PORTS-1:0]      done_s;

    // Selected report
    logic                      rep_vld_s;
    logic [2:0]                rep_code_s;
    logic [2:0]                rep_port_s;
    logic [NUM_CODES-1:0]      sticky_set_s;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_slice
        assign m_cmd_s[g]  = mbus_cmd_i[g*MBUS_CMD_WIDTH +: MBUS_CMD_WIDTH];
        assign m_addr_s[g] = mbus_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign c_cmd_s[g]  = cbus_cmd_i[g*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH];
    end

    // Next-state and violation detection for both FSMs of every port
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            m_state_nxt_s[p]    = m_state_r[p];
            m_cap_cmd_nxt_s[p]  = m_cap_cmd_r[p];
            m_cap_addr_nxt_s[p] = m_cap_addr_r[p];
            to_cnt_nxt_s[p]     = to_cnt_r[p];
            s_state_nxt_s[p]    = s_state_r[p];
            s_cap_cmd_nxt_s[p]  = s_cap_cmd_r[p];
            s_cap_addr_nxt_s[p] = s_cap_addr_r[p];
            port_err_s[p]       = 5'b00000;
            done_s[p]           = 1'b0;

            // Illegal commands are reported every cycle they are present
            if (m_cmd_s[p] > MBUS_MAX) begin
                port_err_s[p][4] = 1'b1;
            end else begin
                port_err_s[p][4] = 1'b0;
            end

            case (m_state_r[p])
                M_IDLE: begin
                    if (m_cmd_s[p] > MBUS_MAX) begin
                        m_state_nxt_s[p] = M_IDLE;
                    end else if (m_cmd_s[p] != MBUS_NOP) begin
                        if (mbus_ack_i[p]) begin
                            done_s[p] = 1'b1;
                        end else begin
                            m_state_nxt_s[p]    = M_WAIT;
                            m_cap_cmd_nxt_s[p]  = m_cmd_s[p];
                            m_cap_addr_nxt_s[p] = m_addr_s[p];
                            to_cnt_nxt_s[p]     = {TO_CNT_WIDTH{1'b0}};
                        end
                    end else if (mbus_ack_i[p]) begin
                        port_err_s[p][1] = 1'b1;
                    end else begin
                        m_state_nxt_s[p] = M_IDLE;
                    end
                end
                M_WAIT: begin
                    if ((m_cmd_s[p] != m_cap_cmd_r[p]) || (m_addr_s[p] != m_cap_addr_r[p])) begin
                        port_err_s[p][0] = 1'b1;
                    end else begin
                        port_err_s[p][0] = 1'b0;
                    end
                    if (mbus_ack_i[p]) begin
                        m_state_nxt_s[p] = M_IDLE;
                        done_s[p]        = 1'b1;
                    end else begin
                        // Counter saturates at the limit so the timeout fires once
                        if (to_cnt_r[p] != TO_LIMIT) begin
                            to_cnt_nxt_s[p] = to_cnt_r[p] + {{(TO_CNT_WIDTH-1){1'b0}}, 1'b1};
                        end else begin
                            to_cnt_nxt_s[p] = to_cnt_r[p];
                        end
                        if (to_cnt_r[p] == TO_LAST) begin
                            port_err_s[p][2] = 1'b1;
                        end else begin
                            port_err_s[p][2] = 1'b0;
                        end
                    end
                end
                default: begin
                    m_state_nxt_s[p] = M_IDLE;
                end
            endcase

            case (s_state_r[p])
                S_IDLE: begin
                    if ((c_cmd_s[p] != CBUS_NOP) && !cbus_ack_i[p]) begin
                        s_state_nxt_s[p]    = S_WAIT;
                        s_cap_cmd_nxt_s[p]  = c_cmd_s[p];
                        s_cap_addr_nxt_s[p] = cbus_addr_i;
                    end else begin
                        s_state_nxt_s[p] = S_IDLE;
                    end
                end
                S_WAIT: begin
                    if ((c_cmd_s[p] != s_cap_cmd_r[p]) || (cbus_addr_i != s_cap_addr_r[p])) begin
                        port_err_s[p][3] = 1'b1;
                    end else begin
                        port_err_s[p][3] = 1'b0;
                    end
                    if (cbus_ack_i[p]) begin
                        s_state_nxt_s[p] = S_IDLE;
                    end else begin
                        s_state_nxt_s[p] = S_WAIT;
                    end
                end
                default: begin
                    s_state_nxt_s[p] = S_IDLE;
                end
            endcase
        end
    end

    // Pick the lowest port, then lowest code; gather every code for the sticky vector
    always_comb begin
        rep_vld_s    = 1'b0;
        rep_code_s   = 3'd0;
        rep_port_s   = 3'd0;
        sticky_set_s = 5'b00000;
        for (int p = 0; p < NUM_PORTS; p++) begin
            sticky_set_s = sticky_set_s | port_err_s[p];
            for (int c = 0; c < NUM_CODES; c++) begin
                if (!rep_vld_s && port_err_s[p][c]) begin
                    rep_vld_s  = 1'b1;
                    rep_code_s = 3'(c);
                    rep_port_s = 3'(p);
                end else begin
                    rep_vld_s  = rep_vld_s;
                end
            end
        end
    end

    // FSM and capture registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                m_state_r[p]    <= M_IDLE;
                m_cap_cmd_r[p]  <= {MBUS_CMD_WIDTH{1'b0}};
                m_cap_addr_r[p] <= {ADDR_WIDTH{1'b0}};
                to_cnt_r[p]     <= {TO_CNT_WIDTH{1'b0}};
                s_state_r[p]    <= S_IDLE;
                s_cap_cmd_r[p]  <= {CBUS_CMD_WIDTH{1'b0}};
                s_cap_addr_r[p] <= {ADDR_WIDTH{1'b0}};
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                m_state_r[p]    <= m_state_nxt_s[p];
                m_cap_cmd_r[p]  <= m_cap_cmd_nxt_s[p];
                m_cap_addr_r[p] <= m_cap_addr_nxt_s[p];
                to_cnt_r[p]     <= to_cnt_nxt_s[p];
                s_state_r[p]    <= s_state_nxt_s[p];
                s_cap_cmd_r[p]  <= s_cap_cmd_nxt_s[p];
                s_cap_addr_r[p] <= s_cap_addr_nxt_s[p];
            end
        end
    end

    // Registered violation report and sticky accumulation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_vld_o    <= 1'b0;
            err_code_o   <= 3'd0;
            err_port_o   <= 3'd0;
            err_sticky_o <= 5'b00000;
        end else begin
            err_vld_o    <= rep_vld_s;
            err_code_o   <= rep_code_s;
            err_port_o   <= rep_port_s;
            err_sticky_o <= err_sticky_o | sticky_set_s;
        end
    end

`ifdef MESI_MON_STATS_EN
    logic [15:0] txn_cnt_r [NUM_PORTS];

    // Saturating count of completed main-bus transactions per port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                txn_cnt_r[p] <= 16'h0000;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (done_s[p] && (txn_cnt_r[p] != 16'hFFFF)) begin
                    txn_cnt_r[p] <= txn_cnt_r[p] + 16'h0001;
                end else begin
                    txn_cnt_r[p] <= txn_cnt_r[p];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_txn
        assign txn_cnt_o[g*16 +: 16] = txn_cnt_r[g];
    end
`else
    // Completion strobes have no consumer without statistics
    logic stats_unused_s;
    assign stats_unused_s = |done_s;
    assign txn_cnt_o      = {(NUM_PORTS*16){1'b0}};
`endif

endmodule

// File: tb/tb_mesi_isc_coh_monitor.sv
// Self-checking bench for mesi_isc_coh_monitor (4 ports, timeout of 8 cycles).
// Expected violation reports are queued with the cycle they must appear in; a
// negedge monitor pops and compares them and flags any unexpected report.
module tb_mesi_isc_coh_monitor;

    localparam int NP = 4;
    localparam int TO = 8;
`ifdef MESI_MON_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NP*3-1:0]  mbus_cmd;
    logic [NP*32-1:0] mbus_addr;
    logic [NP-1:0]    mbus_ack;
    logic [NP*3-1:0]  cbus_cmd;
    logic [31:0]      cbus_addr;
    logic [NP-1:0]    cbus_ack;
    logic             err_vld;
    logic [2:0]       err_code;
    logic [2:0]       err_port;
    logic [4:0]       err_sticky;
    logic [NP*16-1:0] txn_cnt;

    typedef struct {
        int         code;
        int         port;
        int         due;
        logic [4:0] stk;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [4:0] exp_sticky = 5'b00000;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    mesi_isc_coh_monitor #(
        .NUM_PORTS(NP), .MBUS_CMD_WIDTH(3), .CBUS_CMD_WIDTH(3),
        .ADDR_WIDTH(32), .TIMEOUT_CYC(TO), .TO_CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .mbus_cmd_i(mbus_cmd), .mbus_addr_i(mbus_addr), .mbus_ack_i(mbus_ack),
        .cbus_cmd_i(cbus_cmd), .cbus_addr_i(cbus_addr), .cbus_ack_i(cbus_ack),
        .err_vld_o(err_vld), .err_code_o(err_code), .err_port_o(err_port),
        .err_sticky_o(err_sticky), .txn_cnt_o(txn_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: compare reports and the sticky vector on the falling edge
    always @(negedge clk) begin
        if (!rst) exp_sticky = 5'b00000;
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            mon_e = sb_q.pop_front();
            exp_sticky = exp_sticky | mon_e.stk;
            checks++;
            if (err_vld !== 1'b1 || err_code !== 3'(mon_e.code) || err_port !== 3'(mon_e.port)) begin
                errors++;
                $display("FAIL report cyc=%0d: vld=%b code=%0d port=%0d, required vld=1 code=%0d port=%0d",
                         cyc, err_vld, err_code, err_port, mon_e.code, mon_e.port);
            end
        end else begin
            checks++;
            if (err_vld !== 1'b0) begin
                errors++;
                $display("FAIL unexpected_report cyc=%0d: vld=%b code=%0d port=%0d, required vld=0",
                         cyc, err_vld, err_code, err_port);
            end
        end
        checks++;
        if (err_sticky !== exp_sticky) begin
            errors++;
            $display("FAIL sticky cyc=%0d: got %b, required %b", cyc, err_sticky, exp_sticky);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        mbus_cmd  = '0;
        mbus_addr = '0;
        mbus_ack  = '0;
        cbus_cmd  = '0;
        cbus_addr = 32'h0;
        cbus_ack  = '0;
    endtask

    task automatic set_m(input int p, input logic [2:0] cmd, input logic [31:0] addr, input logic ack);
        mbus_cmd[p*3 +: 3]   = cmd;
        mbus_addr[p*32 +: 32] = addr;
        mbus_ack[p]          = ack;
    endtask

    task automatic push(input int code, input int port, input int due, input logic [4:0] stk);
        exp_t e;
        e.code = code;
        e.port = port;
        e.due  = due;
        e.stk  = stk;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        step();
        clear_all();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic check_txn(input int p, input logic [15:0] cnt, input string name);
        logic [15:0] exp;
        exp = STATS ? cnt : 16'h0000;
        checks++;
        if (txn_cnt[p*16 +: 16] !== exp) begin
            errors++;
            $display("FAIL %s: txn_cnt[%0d]=%0d, required %0d", name, p, txn_cnt[p*16 +: 16], exp);
        end
    endtask

    task automatic test_reset();
        clear_all();
        rst = 1'b0;
        step();
        checks++;
        if (err_vld !== 1'b0 || err_code !== 3'd0 || err_port !== 3'd0 ||
            err_sticky !== 5'b00000 || txn_cnt !== '0) begin
            errors++;
            $display("FAIL reset_values: vld=%b code=%0d port=%0d sticky=%b txn=%h, required all zero",
                     err_vld, err_code, err_port, err_sticky, txn_cnt);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_clean_read();
        step(); set_m(2, 3'd2, 32'h1000, 1'b0);
        step();
        step();
        step(); mbus_ack[2] = 1'b1;
        step(); clear_all();
        step();
        check_txn(2, 16'd1, "clean_read_txn");
    endtask

    task automatic test_unstable();
        step(); set_m(1, 3'd1, 32'h40, 1'b0);
        step();
        step(); mbus_addr[1*32 +: 32] = 32'h44; push(0, 1, cyc + 1, 5'b00001);
        step(); mbus_addr[1*32 +: 32] = 32'h40; mbus_ack[1] = 1'b1;
        step(); clear_all();
        step(); step();
        checks++;
        if (err_sticky !== 5'b00001) begin
            errors++;
            $display("FAIL unstable_sticky: got %b, required 00001", err_sticky);
        end
        check_txn(1, 16'd1, "unstable_completes_txn");
    endtask

    task automatic test_timeout();
        step(); set_m(0, 3'd2, 32'h80, 1'b0); push(2, 0, cyc + TO + 1, 5'b00100);
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL timeout_pending: %0d reports outstanding, required 0", sb_q.size());
        end
        mbus_ack[0] = 1'b1;
        step(); clear_all();
        step();
        check_txn(0, 16'd1, "timeout_then_ack_txn");
    endtask

    task automatic test_same_cycle();
        step();
        set_m(3, 3'd6, 32'h0, 1'b0);
        set_m(0, 3'd0, 32'h0, 1'b1);
        push(1, 0, cyc + 1, 5'b10010);
        step(); clear_all();
        step(); step();
        checks++;
        if (err_sticky !== 5'b10010) begin
            errors++;
            $display("FAIL same_cycle_sticky: got %b, required 10010", err_sticky);
        end
    endtask

    task automatic test_snoop();
        step(); cbus_cmd[1*3 +: 3] = 3'd2; cbus_addr = 32'h200;
        step();
        step(); cbus_addr = 32'h204; push(3, 1, cyc + 1, 5'b01000);
        step(); cbus_addr = 32'h200; cbus_ack[1] = 1'b1;
        step(); clear_all();
        step(); step();
    endtask

    task automatic test_reset_mid_wait();
        step(); set_m(2, 3'd2, 32'h300, 1'b0);
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (err_vld !== 1'b0 || err_code !== 3'd0 || err_port !== 3'd0 ||
            err_sticky !== 5'b00000 || txn_cnt !== '0) begin
            errors++;
            $display("FAIL async_reset: vld=%b code=%0d port=%0d sticky=%b txn=%h, required all zero",
                     err_vld, err_code, err_port, err_sticky, txn_cnt);
        end
        clear_all();
        step(); rst = 1'b1;
        step(); set_m(2, 3'd2, 32'h400, 1'b1);
        step(); clear_all();
        step(); step();
        check_txn(2, 16'd1, "post_reset_txn");
        checks++;
        if (err_sticky !== 5'b00000) begin
            errors++;
            $display("FAIL post_reset_sticky: got %b, required 00000", err_sticky);
        end
    endtask

    task automatic test_back_to_back();
        step(); set_m(3, 3'd2, 32'h10, 1'b0);
        step(); mbus_ack[3] = 1'b1;
        step(); set_m(3, 3'd1, 32'h20, 1'b1);
        step(); set_m(3, 3'd2, 32'h30, 1'b0);
        step(); mbus_ack[3] = 1'b1;
        step(); clear_all();
        step(); step();
        check_txn(3, 16'd3, "back_to_back_txn");
    endtask

    initial begin
        test_reset();
        test_clean_read();
        test_unstable();
        do_reset();
        test_timeout();
        do_reset();
        test_same_cycle();
        do_reset();
        test_snoop();
        test_reset_mid_wait();
        test_back_to_back();
        step(); step();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: %0d reports never seen, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mesi_isc_coh_monitor.md
Name: mesi_isc_coh_monitor

Overview:
Parametrised, synthesizable protocol monitor for the MESI intersection controller, generalising the fixed 4-port property binding to NUM_PORTS main/coherence bus pairs. It observes every main-bus request/ack handshake and every coherence-bus snoop/ack handshake on each port. It flags protocol violations: instability, spurious ack, timeout and illegal command. It is bound or instantiated alongside mesi_isc and is usable both in simulation and in formal runs.

Parameters:
NUM_PORTS, 4, number of cache ports monitored (1..8)
MBUS_CMD_WIDTH, 3, main-bus command width
CBUS_CMD_WIDTH, 3, coherence-bus command width
ADDR_WIDTH, 32, address width
TIMEOUT_CYC, 64, max cycles a main-bus request may wait for ack (2..65535)
TO_CNT_WIDTH, 16, timeout counter width (must be >= clog2(TIMEOUT_CYC+1))

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
mbus_cmd_i  input  NUM_PORTS*MBUS_CMD_WIDTH  main-bus commands, port p at slice p
mbus_addr_i  input  NUM_PORTS*ADDR_WIDTH  main-bus addresses
mbus_ack_i  input  NUM_PORTS  main-bus acks from mesi_isc
cbus_cmd_i  input  NUM_PORTS*CBUS_CMD_WIDTH  coherence-bus commands from mesi_isc
cbus_addr_i  input  ADDR_WIDTH  shared coherence-bus address
cbus_ack_i  input  NUM_PORTS  coherence-bus acks from caches
err_vld_o  output  1  one-cycle pulse, violation detected
err_code_o  output  3  code of the reported violation
err_port_o  output  3  port of the reported violation
err_sticky_o  output  5  sticky OR of all codes seen, bit k = code k
txn_cnt_o  output  NUM_PORTS*16  completed main-bus transactions per port (optional feature)

Behaviour:
- Command encodings. MBUS: NOP=0, WR=1, RD=2, WR_BROAD=3, RD_BROAD=4, values 5..7 illegal. CBUS: NOP=0, WR_SNOOP=1, RD_SNOOP=2, EN_WR=3, EN_RD=4.
- Reset (rst=0, async): all FSMs go to IDLE and all counters clear. err_vld_o=0, err_code_o=0, err_port_o=0, err_sticky_o=0, txn_cnt_o=0.
- Main FSM per port, states IDLE and WAIT:
  - IDLE, cmd!=NOP, ack=0: capture cmd/addr, clear the timeout counter, go to WAIT.
  - IDLE, cmd!=NOP, ack=1: zero-latency completion, stay IDLE, count a transaction.
  - WAIT: counter increments each cycle.
  - WAIT, ack=1: go to IDLE and count a transaction; cmd/addr must still equal the captured values in that cycle.
  - Back-to-back: a new command in the cycle after an ack is evaluated from IDLE.
- Snoop FSM per port, states S_IDLE and S_WAIT:
  - S_IDLE, cbus_cmd!=NOP, ack=0: capture cmd and cbus_addr, go to S_WAIT.
  - S_WAIT, cbus_ack=1: go to S_IDLE.
  - cbus_cmd!=NOP with cbus_ack=1 in the same cycle completes immediately.
- Violation codes:
  - 0 CMD_UNSTABLE: in WAIT, cmd or addr differs from the captured values (includes a drop to NOP).
  - 1 ACK_NO_REQ: mbus_ack=1 while in IDLE with cmd=NOP.
  - 2 TIMEOUT: counter reaches TIMEOUT_CYC while in WAIT. Flagged once; the FSM stays in WAIT and the counter saturates.
  - 3 SNOOP_UNSTABLE: in S_WAIT, cbus_cmd or cbus_addr differs from the captured values.
  - 4 ILLEGAL_CMD: mbus cmd > 4. Flagged every cycle it is present; no FSM transition.
- Reporting: violations are detected combinationally in cycle N and reported registered in cycle N+1.
- Multiple violations in one cycle: report the lowest port, then the lowest code. Every detected code sets its err_sticky_o bit regardless of which one is reported.
- After an instability violation the FSM still completes on ack and does not re-capture.

Optional Feature:
- MESI_MON_STATS_EN defined: txn_cnt_o holds a per-port 16-bit counter that increments on each completed main-bus transaction and saturates at 0xFFFF.
- MESI_MON_STATS_EN undefined: the txn_cnt_o port is still present, driven constant 0, and no counter flops are generated.

Test Plan:
- Port 2 RD addr 0x1000, ack after 3 cycles, stable throughout -> no err_vld_o; txn_cnt_o[2]=1 (stats on).
- Port 1 WR addr 0x40, addr changes to 0x44 on cycle 2 of WAIT -> err_vld_o pulse next cycle, code 0, port 1, err_sticky_o=5'b00001.
- TIMEOUT_CYC=8, port 0 RD never acked -> single err_vld_o, code 2, port 0, registered one cycle after the 8th wait cycle; no repeat pulse.
- Same cycle: port 3 drives cmd=6 and port 0 gets mbus_ack with cmd=NOP -> next cycle code 1, port 0; err_sticky_o=5'b10010.
- cbus_cmd1=RD_SNOOP at 0x200, cbus_addr changes before cbus_ack1 -> code 3, port 1.
- rst low mid-WAIT on port 2 -> all outputs 0 immediately; after release a fresh RD with immediate ack gives no error.
